// File: rtl/car_collision_detector_if.sv
// Pixel-stream inputs and game-status outputs of the car collision detector.
// master: pixel/timing source side; slave: the detector.
interface car_collision_detector_if;
  logic [9:0]  pix_row;
  logic [9:0]  pix_col;
  logic        video_on;
  logic [11:0] obstacle_pix;
  logic [11:0] player_pix;
  logic [1:0]  level_in;
  logic        restart;
  logic        collision;
  logic [1:0]  lives;
  logic        freeze;
  logic        game_over;
  logic [15:0] overlap_last;

  modport master (
    output pix_row, pix_col, video_on, obstacle_pix, player_pix, level_in, restart,
    input  collision, lives, freeze, game_over, overlap_last
  );

  modport slave (
    input  pix_row, pix_col, video_on, obstacle_pix, player_pix, level_in, restart,
    output collision, lives, freeze, game_over, overlap_last
  );
endinterface

// File: rtl/car_collision_detector.sv
// Per-frame overlap counter plus lives / freeze / game-over FSM for the racing game.
// Define LEVEL_THRESHOLD_EN to shrink the hit threshold as level_in rises.
//
// state     | meaning
// RUN       | normal play, a frame with enough overlap costs a life
// HIT       | post-hit immunity, counts down FREEZE_FRAMES frame ends
// GAME_OVER | no lives left, waits for restart
module car_collision_detector #(
  parameter int          FRAME_ROWS    = 480,
  parameter int          FRAME_COLS    = 640,
  parameter int          HIT_THRESHOLD = 16,
  parameter int          LIVES         = 3,
  parameter int          FREEZE_FRAMES = 60,
  parameter logic [11:0] BG_COLOR      = 12'h000
) (
  input logic                     clk,
  input logic                     reset,
  car_collision_detector_if.slave bus
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] HIT       = 2'd1;
  localparam logic [1:0] GAME_OVER = 2'd2;

  localparam logic [9:0]  LAST_ROW    = 10'(FRAME_ROWS - 1);
  localparam logic [9:0]  LAST_COL    = 10'(FRAME_COLS - 1);
  localparam logic [15:0] THR_BASE    = 16'(HIT_THRESHOLD);
  localparam logic [1:0]  LIVES_INIT  = 2'(LIVES);
  localparam logic [7:0]  FREEZE_INIT = 8'(FREEZE_FRAMES);

  logic [1:0]  state;
  logic [1:0]  lives_q;
  logic        collision_q;
  logic [7:0]  freeze_cnt;
  logic [15:0] ov_cnt;
  logic [15:0] overlap_last_q;

  logic [9:0]  row_d;
  logic [9:0]  col_d;
  logic        video_on_d;

  logic        ov;
  logic        eof;
  logic [15:0] cnt_final;
  logic [15:0] thr;

  // Pixel inputs are registered upstream, so realign the coordinates to them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_d      <= '0;
      col_d      <= '0;
      video_on_d <= 1'b0;
    end else begin
      row_d      <= bus.pix_row;
      col_d      <= bus.pix_col;
      video_on_d <= bus.video_on;
    end
  end

  assign ov  = video_on_d && (bus.obstacle_pix != BG_COLOR) && (bus.player_pix != BG_COLOR);
  assign eof = video_on_d && (row_d == LAST_ROW) && (col_d == LAST_COL);

  // Count including the current pixel; saturates rather than wrapping.
  assign cnt_final = (ov && (ov_cnt != 16'hFFFF)) ? ov_cnt + 16'd1 : ov_cnt;

`ifdef LEVEL_THRESHOLD_EN
  logic [15:0] thr_shift;
  assign thr_shift = THR_BASE >> bus.level_in;
  assign thr       = (thr_shift == 16'd0) ? 16'd1 : thr_shift;
`else
  logic unused_level;
  assign unused_level = ^bus.level_in;
  assign thr          = THR_BASE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_cnt         <= '0;
      overlap_last_q <= '0;
    end else if (bus.restart) begin
      ov_cnt         <= '0;
      overlap_last_q <= '0;
    end else if (eof) begin
      ov_cnt         <= '0;
      overlap_last_q <= cnt_final;
    end else begin
      ov_cnt         <= cnt_final;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      lives_q     <= LIVES_INIT;
      collision_q <= 1'b0;
      freeze_cnt  <= '0;
    end else if (bus.restart) begin
      state       <= RUN;
      lives_q     <= LIVES_INIT;
      collision_q <= 1'b0;
      freeze_cnt  <= '0;
    end else begin
      collision_q <= 1'b0;
      if (eof) begin
        case (state)
          RUN: begin
            if (cnt_final >= thr) begin
              collision_q <= 1'b1;
              if (lives_q == 2'd1) begin
                lives_q <= 2'd0;
                state   <= GAME_OVER;
              end else begin
                lives_q    <= lives_q - 2'd1;
                freeze_cnt <= FREEZE_INIT;
                state      <= HIT;
              end
            end
          end
          HIT: begin
            // Terminal count: the frame end that takes the counter to zero ends immunity.
            if (freeze_cnt <= 8'd1) begin
              freeze_cnt <= '0;
              state      <= RUN;
            end else begin
              freeze_cnt <= freeze_cnt - 8'd1;
            end
          end
          GAME_OVER: lives_q <= 2'd0;
          default:   state   <= RUN;
        endcase
      end
    end
  end

  assign bus.collision    = collision_q;
  assign bus.lives        = lives_q;
  assign bus.freeze       = (state == HIT);
  assign bus.game_over    = (state == GAME_OVER);
  assign bus.overlap_last = overlap_last_q;

endmodule

// File: tb/tb_car_collision_detector.sv
// Directed bench for car_collision_detector on a reduced 8x16 frame.
module tb_car_collision_detector;
  localparam int ROWS  = 8;
  localparam int COLS  = 16;
  localparam int NPIX  = ROWS * COLS;
  localparam int BLANK = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  car_collision_detector_if bus ();

  car_collision_detector #(
    .FRAME_ROWS(ROWS), .FRAME_COLS(COLS), .HIT_THRESHOLD(16),
    .LIVES(3), .FREEZE_FRAMES(4), .BG_COLOR(12'h000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int pulses;
  int pulse_k;
  logic [1:0]  snap_lives;
  logic        snap_freeze, snap_game_over, snap_collision;
  logic [15:0] snap_ol;

  // One frame plus blanking; pixel data trails the coordinates by one cycle.
  task automatic drive_frame(input int n_ov, input int ov_start, input bit rst_eof, input int reset_at);
    pulses  = 0;
    pulse_k = -1;
    for (int k = 0; k < NPIX + BLANK; k++) begin
      if (k < NPIX) begin
        bus.video_on = 1'b1;
        bus.pix_row  = 10'(k / COLS);
        bus.pix_col  = 10'(k % COLS);
      end else begin
        bus.video_on = 1'b0;
        bus.pix_row  = '0;
        bus.pix_col  = '0;
      end
      if (k >= 1 && (k - 1) >= ov_start && (k - 1) < ov_start + n_ov) begin
        bus.obstacle_pix = 12'hF00;
        bus.player_pix   = 12'h0F0;
      end else if (k % 2 == 0) begin
        bus.obstacle_pix = 12'hF00;
        bus.player_pix   = 12'h000;
      end else begin
        bus.obstacle_pix = 12'h000;
        bus.player_pix   = 12'h0F0;
      end
      bus.restart = rst_eof && (k == NPIX);
      if (k == reset_at) begin
        #2 reset = 1'b1;
        #2;
        snap_lives     = bus.lives;
        snap_freeze    = bus.freeze;
        snap_game_over = bus.game_over;
        snap_collision = bus.collision;
        snap_ol        = bus.overlap_last;
        reset = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.collision === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
    end
    bus.restart = 1'b0;
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(posedge clk);
    #1;
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++; if (bus.collision !== 1'b0) begin tests_failed++; $display("FAIL reset_collision got %0d exp 0", bus.collision); end
    tests_run++; if (bus.lives !== 2'd3) begin tests_failed++; $display("FAIL reset_lives got %0d exp 3", bus.lives); end
    tests_run++; if (bus.freeze !== 1'b0) begin tests_failed++; $display("FAIL reset_freeze got %0d exp 0", bus.freeze); end
    tests_run++; if (bus.game_over !== 1'b0) begin tests_failed++; $display("FAIL reset_game_over got %0d exp 0", bus.game_over); end
    tests_run++; if (bus.overlap_last !== 16'd0) begin tests_failed++; $display("FAIL reset_overlap_last got %0d exp 0", bus.overlap_last); end
  endtask

  task automatic test_hit();
    drive_frame(20, 0, 1'b0, -1);
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL hit_pulses got %0d exp 1", pulses); end
    tests_run++; if (pulse_k !== NPIX) begin tests_failed++; $display("FAIL hit_latency got %0d exp %0d", pulse_k, NPIX); end
    tests_run++; if (bus.lives !== 2'd2) begin tests_failed++; $display("FAIL hit_lives got %0d exp 2", bus.lives); end
    tests_run++; if (bus.freeze !== 1'b1) begin tests_failed++; $display("FAIL hit_freeze got %0d exp 1", bus.freeze); end
    tests_run++; if (bus.overlap_last !== 16'd20) begin tests_failed++; $display("FAIL hit_overlap_last got %0d exp 20", bus.overlap_last); end
    do_restart();
  endtask

  task automatic test_below_threshold();
    drive_frame(15, 0, 1'b0, -1);
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL below_pulses got %0d exp 0", pulses); end
    tests_run++; if (bus.lives !== 2'd3) begin tests_failed++; $display("FAIL below_lives got %0d exp 3", bus.lives); end
    tests_run++; if (bus.overlap_last !== 16'd15) begin tests_failed++; $display("FAIL below_overlap_last got %0d exp 15", bus.overlap_last); end
    drive_frame(0, 0, 1'b0, -1);
    tests_run++; if (bus.overlap_last !== 16'd0) begin tests_failed++; $display("FAIL empty_overlap_last got %0d exp 0", bus.overlap_last); end
    drive_frame(16, 40, 1'b0, -1);
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL exact_thr_pulses got %0d exp 1", pulses); end
    tests_run++; if (bus.lives !== 2'd2) begin tests_failed++; $display("FAIL exact_thr_lives got %0d exp 2", bus.lives); end
    do_restart();
  endtask

  task automatic test_freeze();
    drive_frame(20, 0, 1'b0, -1);
    tests_run++; if (bus.lives !== 2'd2) begin tests_failed++; $display("FAIL freeze_first_lives got %0d exp 2", bus.lives); end
    for (int f = 1; f <= 4; f++) begin
      drive_frame(100, 0, 1'b0, -1);
      tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL freeze_pulses frame %0d got %0d exp 0", f, pulses); end
      tests_run++; if (bus.freeze !== (f < 4)) begin tests_failed++; $display("FAIL freeze_flag frame %0d got %0d exp %0d", f, bus.freeze, (f < 4)); end
      tests_run++; if (bus.overlap_last !== 16'd100) begin tests_failed++; $display("FAIL freeze_overlap_last got %0d exp 100", bus.overlap_last); end
    end
    drive_frame(100, 0, 1'b0, -1);
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL rehit_pulses got %0d exp 1", pulses); end
    tests_run++; if (bus.lives !== 2'd1) begin tests_failed++; $display("FAIL rehit_lives got %0d exp 1", bus.lives); end
    tests_run++; if (bus.freeze !== 1'b1) begin tests_failed++; $display("FAIL rehit_freeze got %0d exp 1", bus.freeze); end
    do_restart();
  endtask

  task automatic test_game_over();
    for (int h = 1; h <= 2; h++) begin
      drive_frame(20, 0, 1'b0, -1);
      repeat (4) drive_frame(0, 0, 1'b0, -1);
    end
    tests_run++; if (bus.lives !== 2'd1) begin tests_failed++; $display("FAIL go_pre_lives got %0d exp 1", bus.lives); end
    drive_frame(20, 0, 1'b0, -1);
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL go_pulses got %0d exp 1", pulses); end
    tests_run++; if (bus.lives !== 2'd0) begin tests_failed++; $display("FAIL go_lives got %0d exp 0", bus.lives); end
    tests_run++; if (bus.game_over !== 1'b1) begin tests_failed++; $display("FAIL go_flag got %0d exp 1", bus.game_over); end
    tests_run++; if (bus.freeze !== 1'b0) begin tests_failed++; $display("FAIL go_freeze got %0d exp 0", bus.freeze); end
    drive_frame(100, 0, 1'b0, -1);
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL go_ignore_pulses got %0d exp 0", pulses); end
    tests_run++; if (bus.game_over !== 1'b1) begin tests_failed++; $display("FAIL go_hold got %0d exp 1", bus.game_over); end
    do_restart();
    tests_run++; if (bus.lives !== 2'd3) begin tests_failed++; $display("FAIL go_restart_lives got %0d exp 3", bus.lives); end
    tests_run++; if (bus.game_over !== 1'b0) begin tests_failed++; $display("FAIL go_restart_flag got %0d exp 0", bus.game_over); end
    tests_run++; if (bus.overlap_last !== 16'd0) begin tests_failed++; $display("FAIL go_restart_ol got %0d exp 0", bus.overlap_last); end
    drive_frame(20, 0, 1'b0, -1);
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL go_run_again got %0d exp 1", pulses); end
    do_restart();
  endtask

  task automatic test_restart_eof();
    drive_frame(50, 0, 1'b1, -1);
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL rst_eof_pulses got %0d exp 0", pulses); end
    tests_run++; if (bus.lives !== 2'd3) begin tests_failed++; $display("FAIL rst_eof_lives got %0d exp 3", bus.lives); end
    tests_run++; if (bus.overlap_last !== 16'd0) begin tests_failed++; $display("FAIL rst_eof_ol got %0d exp 0", bus.overlap_last); end
  endtask

  task automatic test_async_reset();
    drive_frame(20, 0, 1'b0, -1);
    tests_run++; if (bus.lives !== 2'd2) begin tests_failed++; $display("FAIL ar_pre_lives got %0d exp 2", bus.lives); end
    drive_frame(18, 20, 1'b0, 5);
    tests_run++; if (snap_lives !== 2'd3) begin tests_failed++; $display("FAIL ar_lives got %0d exp 3", snap_lives); end
    tests_run++; if (snap_freeze !== 1'b0) begin tests_failed++; $display("FAIL ar_freeze got %0d exp 0", snap_freeze); end
    tests_run++; if (snap_game_over !== 1'b0) begin tests_failed++; $display("FAIL ar_game_over got %0d exp 0", snap_game_over); end
    tests_run++; if (snap_collision !== 1'b0) begin tests_failed++; $display("FAIL ar_collision got %0d exp 0", snap_collision); end
    tests_run++; if (snap_ol !== 16'd0) begin tests_failed++; $display("FAIL ar_ol got %0d exp 0", snap_ol); end
    tests_run++; if (bus.overlap_last !== 16'd18) begin tests_failed++; $display("FAIL ar_partial_ol got %0d exp 18", bus.overlap_last); end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL ar_partial_hit got %0d exp 1", pulses); end
    do_restart();
  endtask

  task automatic test_level();
    int exp_pulses;
    bus.level_in = 2'd3;
    drive_frame(2, 10, 1'b0, -1);
`ifdef LEVEL_THRESHOLD_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    tests_run++; if (pulses !== exp_pulses) begin tests_failed++; $display("FAIL level3_pulses got %0d exp %0d", pulses, exp_pulses); end
    tests_run++; if (bus.lives !== 2'(3 - exp_pulses)) begin tests_failed++; $display("FAIL level3_lives got %0d exp %0d", bus.lives, 3 - exp_pulses); end
    do_restart();
    bus.level_in = 2'd0;
    drive_frame(15, 0, 1'b0, -1);
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL level0_pulses got %0d exp 0", pulses); end
  endtask

  initial begin
    reset            = 1'b1;
    bus.pix_row      = '0;
    bus.pix_col      = '0;
    bus.video_on     = 1'b0;
    bus.obstacle_pix = '0;
    bus.player_pix   = '0;
    bus.level_in     = 2'd0;
    bus.restart      = 1'b0;
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_hit();
    test_below_threshold();
    test_freeze();
    test_game_over();
    test_restart_eof();
    test_async_reset();
    test_level();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end
endmodule
